wb_mem_arb: RTL and testbench

- Parametrised Wishbone-style memory slave with an N-port round-robin arbiter and a programmable wait-state counter.
- Replaces the fixed single-master instruction/data responder on the CPU side.
- Serves CPU instruction fetch, CPU data and future DMA/debug masters from one shared word array.
- Handshake naming follows the CPU bus: STB/WE/ADR/DAT with AKN as the acknowledge.

---
 rtl/wb_mem_pkg.sv | 34 +++
 rtl/wb_rr_arbiter.sv | 41 ++++
 rtl/wb_mem_arb.sv | 191 +++++++++++++++++++
 tb/tb_wb_mem_arb.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_mem_pkg.sv
`default_nettype none
//==============================================================================
// Package  : wb_mem_pkg
// Purpose  : Shared types and constants for the multi-port Wishbone-style
//            memory slave (wb_mem_arb) and its round-robin arbiter.
//            Holds the transaction state encoding, default widths, the
//            wait-state counter width and a port-slice index helper.
// Revision : 1.0 - initial release
//==============================================================================
package wb_mem_pkg;

    // Transaction states: request sampling, programmable wait, acknowledge.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam int c_DEF_NUM_PORTS   = 2;
    localparam int c_DEF_ADDR_W      = 32;
    localparam int c_DEF_DATA_W      = 32;
    localparam int c_DEF_DEPTH       = 1024;
    localparam int c_DEF_WAIT_CYCLES = 1;

    // Wide enough for the largest wait-state setting (15).
    localparam int c_WAIT_CNT_W = 4;

    // Lowest bit of port idx's slice in a flattened per-port bus.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage : wb_mem_pkg
`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : wb_rr_arbiter
// Purpose  : Purely combinational round-robin selector. Picks the first
//            requesting port at or after i_start, wrapping modulo NUM_PORTS.
// Ports    : i_req       - per-port request vector
//            i_start     - highest-priority port for this decision
//            o_grant     - index of the selected port
//            o_valid     - at least one request is present
// Revision : 1.0 - initial release
//==============================================================================
module wb_rr_arbiter
    import wb_mem_pkg::*;
#(
    parameter int NUM_PORTS = c_DEF_NUM_PORTS,
    parameter int GNT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [GNT_W-1:0]     i_start,
    output logic [GNT_W-1:0]     o_grant,
    output logic                 o_valid
);

    // Scan from the farthest candidate towards i_start so that the last
    // hit written (the nearest one in rotation order) wins.
    always_comb begin
        int w_p;
        w_p     = 0;
        o_valid = 1'b0;
        o_grant = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            w_p = (int'(i_start) + i) % NUM_PORTS;
            if (i_req[w_p]) begin
                o_valid = 1'b1;
                o_grant = GNT_W'(w_p);
            end
        end
    end

endmodule : wb_rr_arbiter
`default_nettype wire

// File: rtl/wb_mem_arb.sv
`default_nettype none
//==============================================================================
// Module   : wb_mem_arb
// Purpose  : Shared word memory serving NUM_PORTS Wishbone-style masters
//            through a round-robin arbiter and a programmable wait-state
//            counter (IDLE -> WAIT x WAIT_CYCLES -> ACK -> IDLE).
// Ports    : CLK_I  - clock, rising edge
//            RST_I  - asynchronous active-low reset
//            STB_I  - per-port strobe, held until acknowledged
//            WE_I   - per-port write enable
//            ADR_I  - per-port byte address (port p in slice p)
//            DAT_I  - per-port write data
//            DAT_O  - per-port read data, held until that port's next read
//            AKN_O  - per-port one-cycle acknowledge
//            ERR_O  - per-port one-cycle error (WB_MEM_ERR_EN builds only)
//            GNT_O  - index of the current / last granted port
// Config   : `define WB_MEM_ERR_EN to flag addresses beyond DEPTH words with
//            ERR_O instead of wrapping them modulo DEPTH.
// Revision : 1.0 - initial release
//==============================================================================
module wb_mem_arb
    import wb_mem_pkg::*;
#(
    parameter int NUM_PORTS   = c_DEF_NUM_PORTS,
    parameter int ADDR_W      = c_DEF_ADDR_W,
    parameter int DATA_W      = c_DEF_DATA_W,
    parameter int DEPTH       = c_DEF_DEPTH,
    parameter int WAIT_CYCLES = c_DEF_WAIT_CYCLES,
    localparam int GNT_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                        CLK_I,
    input  logic                        RST_I,
    input  logic [NUM_PORTS-1:0]        STB_I,
    input  logic [NUM_PORTS-1:0]        WE_I,
    input  logic [NUM_PORTS*ADDR_W-1:0] ADR_I,
    input  logic [NUM_PORTS*DATA_W-1:0] DAT_I,
    output logic [NUM_PORTS*DATA_W-1:0] DAT_O,
    output logic [NUM_PORTS-1:0]        AKN_O,
`ifdef WB_MEM_ERR_EN
    output logic [NUM_PORTS-1:0]        ERR_O,
`endif
    output logic [GNT_W-1:0]            GNT_O
);

    localparam int c_IDX_W = $clog2(DEPTH);

    state_t                  r_state, w_state_nxt;
    logic [c_WAIT_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [GNT_W-1:0]        r_port;      // granted port, also drives GNT_O
    logic [GNT_W-1:0]        r_rr_ptr;    // first port considered next time
    logic [GNT_W-1:0]        w_gnt;
    logic                    w_gnt_valid;

    logic                    r_we;
    logic [c_IDX_W-1:0]      r_addr;
    logic [DATA_W-1:0]       r_wdata;
    logic                    r_oob;

    logic [DATA_W-1:0]       r_dat [NUM_PORTS];
    logic [DATA_W-1:0]       r_mem [DEPTH];

    logic [ADDR_W-1:0]       w_sel_adr;
    logic [DATA_W-1:0]       w_sel_dat;
    logic                    w_sel_we;
    logic                    w_sel_oob;
    logic                    w_ack_ok;

    wb_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .GNT_W     (GNT_W)
    ) u_arb (
        .i_req     (STB_I),
        .i_start   (r_rr_ptr),
        .o_grant   (w_gnt),
        .o_valid   (w_gnt_valid)
    );

    // Request fields of the port the arbiter currently selects.
    always_comb begin
        w_sel_adr = ADR_I[slice_lo(int'(w_gnt), ADDR_W) +: ADDR_W];
        w_sel_dat = DAT_I[slice_lo(int'(w_gnt), DATA_W) +: DATA_W];
        w_sel_we  = WE_I[w_gnt];
    end

`ifdef WB_MEM_ERR_EN
    // Any bit above the word-index field marks the request out of range.
    localparam logic [ADDR_W-1:0] c_IN_RANGE_MASK =
        ADDR_W'((64'd1 << (c_IDX_W + 2)) - 64'd1);
    logic w_unused_adr_bits;
    assign w_sel_oob         = |(w_sel_adr & ~c_IN_RANGE_MASK);
    assign w_unused_adr_bits = &{1'b0, w_sel_adr[1:0]};
`else
    // Upper address bits are dropped, so the array aliases modulo DEPTH.
    logic w_unused_adr_bits;
    assign w_sel_oob         = 1'b0;
    assign w_unused_adr_bits = &{1'b0, w_sel_adr[1:0],
                                 w_sel_adr[ADDR_W-1:c_IDX_W+2]};
`endif

    // Next-state / wait counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_valid) begin
                    w_cnt_nxt   = c_WAIT_CNT_W'(WAIT_CYCLES);
                    w_state_nxt = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == c_WAIT_CNT_W'(1)) begin
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_ack_ok = (r_state == ST_ACK) && !r_oob;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_port   <= '0;
            r_rr_ptr <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_oob    <= 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_dat[p] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            // Requests are only sampled in IDLE; later STB changes are ignored.
            if (r_state == ST_IDLE && w_gnt_valid) begin
                r_port  <= w_gnt;
                r_we    <= w_sel_we;
                r_addr  <= w_sel_adr[c_IDX_W+1:2];
                r_wdata <= w_sel_dat;
                r_oob   <= w_sel_oob;
            end
            if (r_state == ST_ACK) begin
                r_rr_ptr <= (r_port == GNT_W'(NUM_PORTS - 1)) ? '0 : r_port + 1'b1;
                if (w_ack_ok && !r_we) begin
                    r_dat[r_port] <= r_mem[r_addr];
                end
            end
        end
    end

    // Storage is never reset. An asynchronous reset forces IDLE, so an
    // interrupted write can never reach this port.
    always_ff @(posedge CLK_I) begin
        if (w_ack_ok && r_we) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    // Read data is driven straight from the array during the ACK cycle and
    // captured at its closing edge for the hold period.
    always_comb begin
        AKN_O = '0;
        DAT_O = '0;
        if (w_ack_ok) begin
            AKN_O[r_port] = 1'b1;
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            DAT_O[p*DATA_W +: DATA_W] =
                (w_ack_ok && !r_we && r_port == GNT_W'(p)) ? r_mem[r_addr] : r_dat[p];
        end
    end

`ifdef WB_MEM_ERR_EN
    always_comb begin
        ERR_O = '0;
        if (r_state == ST_ACK && r_oob) begin
            ERR_O[r_port] = 1'b1;
        end
    end
`endif

    assign GNT_O = r_port;

endmodule : wb_mem_arb
`default_nettype wire

// File: tb/tb_wb_mem_arb.sv
`default_nettype none
//==============================================================================
// Module   : tb_wb_mem_arb
// Purpose  : Self-checking bench for wb_mem_arb: a 2-port WAIT_CYCLES=1
//            instance driven from a vector table plus hand-written sequences,
//            and two 1-port instances with WAIT_CYCLES=0 and 15.
// Revision : 1.0 - initial release
//==============================================================================
module tb_wb_mem_arb;

    logic clk;
    logic rst_n;

    // Main instance: 2 ports, 1 wait state.
    logic [1:0]  stb, we, akn;
    logic [63:0] adr, dat_i, dat_o;
    logic [0:0]  gnt;
`ifdef WB_MEM_ERR_EN
    logic [1:0]  err;
`endif

    // Single-port instances for the wait-state extremes.
    logic [0:0]  stb0, we0, akn0, gnt0, stb15, we15, akn15, gnt15;
    logic [31:0] adr0, din0, dout0, adr15, din15, dout15;
`ifdef WB_MEM_ERR_EN
    logic [0:0]  err0, err15;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    wb_mem_arb #(.NUM_PORTS(2), .WAIT_CYCLES(1)) dut (
        .CLK_I(clk), .RST_I(rst_n), .STB_I(stb), .WE_I(we), .ADR_I(adr),
        .DAT_I(dat_i), .DAT_O(dat_o), .AKN_O(akn),
`ifdef WB_MEM_ERR_EN
        .ERR_O(err),
`endif
        .GNT_O(gnt)
    );

    wb_mem_arb #(.NUM_PORTS(1), .DEPTH(16), .WAIT_CYCLES(0)) dut_w0 (
        .CLK_I(clk), .RST_I(rst_n), .STB_I(stb0), .WE_I(we0), .ADR_I(adr0),
        .DAT_I(din0), .DAT_O(dout0), .AKN_O(akn0),
`ifdef WB_MEM_ERR_EN
        .ERR_O(err0),
`endif
        .GNT_O(gnt0)
    );

    wb_mem_arb #(.NUM_PORTS(1), .DEPTH(16), .WAIT_CYCLES(15)) dut_w15 (
        .CLK_I(clk), .RST_I(rst_n), .STB_I(stb15), .WE_I(we15), .ADR_I(adr15),
        .DAT_I(din15), .DAT_O(dout15), .AKN_O(akn15),
`ifdef WB_MEM_ERR_EN
        .ERR_O(err15),
`endif
        .GNT_O(gnt15)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t vecs [8];

    // Records filled by watch_acks.
    int          na;
    int          ack_n [4];
    logic [1:0]  ack_v [4];
    logic [0:0]  ack_g [4];
    logic [63:0] ack_d [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One transaction on the main instance; called just after a falling edge.
    task automatic txn(input int p, input logic w, input logic [31:0] a,
                       input logic [31:0] d, output int lat, output logic [31:0] rd,
                       output logic [0:0] g, output logic ok, output logic errd);
        stb[p] = 1'b1;
        we[p]  = w;
        adr[p*32 +: 32]   = a;
        dat_i[p*32 +: 32] = d;
        lat = 0; rd = '0; g = '0; ok = 1'b0; errd = 1'b0;
        for (int n = 1; n <= 40 && !ok && !errd; n++) begin
            @(posedge clk); @(negedge clk);
            if (akn[p]) begin
                ok = 1'b1; lat = n; rd = dat_o[p*32 +: 32]; g = gnt;
            end
`ifdef WB_MEM_ERR_EN
            if (err[p]) begin
                errd = 1'b1; lat = n; g = gnt;
            end
`endif
        end
        stb[p] = 1'b0;
        @(posedge clk); @(negedge clk);
        check("akn_single_pulse", 64'(akn), 64'd0);
    endtask

    // Observe acknowledges on the main instance while STB is held.
    task automatic watch_acks(input int want, input logic drop_each);
        na = 0;
        for (int i = 0; i < 4; i++) begin
            ack_n[i] = 0; ack_v[i] = '0; ack_g[i] = '0; ack_d[i] = '0;
        end
        for (int n = 1; n <= 60 && na < want; n++) begin
            @(posedge clk); @(negedge clk);
            if (akn != 2'b00) begin
                ack_n[na] = n; ack_v[na] = akn; ack_g[na] = gnt; ack_d[na] = dat_o;
                na++;
                if (drop_each) stb = stb & ~akn;
            end
        end
        stb = 2'b00;
    endtask

    // Held-STB write burst then a read on a single-port instance.
    task automatic small_burst(input int sel, input int wc);
        int t [3];
        int seen;
        int lat;
        logic a;
        logic [31:0] rd;
        t = '{0, 0, 0};
        seen = 0;
        if (sel == 0) begin stb0 = 1'b1; we0 = 1'b1; adr0 = 32'h8; din0 = 32'hA0; end
        else          begin stb15 = 1'b1; we15 = 1'b1; adr15 = 32'h8; din15 = 32'hB0; end
        for (int n = 1; n <= 80 && seen < 3; n++) begin
            @(posedge clk); @(negedge clk);
            a = (sel == 0) ? akn0[0] : akn15[0];
            if (a) begin t[seen] = n; seen++; end
        end
        stb0 = 1'b0; stb15 = 1'b0;
        check($sformatf("w%0d_ack_count", wc), 64'(seen), 64'd3);
        check($sformatf("w%0d_first_lat", wc), 64'(t[0]), 64'(wc + 1));
        check($sformatf("w%0d_gap1", wc), 64'(t[1] - t[0]), 64'(wc + 2));
        check($sformatf("w%0d_gap2", wc), 64'(t[2] - t[1]), 64'(wc + 2));
        @(posedge clk); @(negedge clk);
        if (sel == 0) begin stb0 = 1'b1; we0 = 1'b0; end
        else          begin stb15 = 1'b1; we15 = 1'b0; end
        lat = 0; rd = '0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(posedge clk); @(negedge clk);
            a = (sel == 0) ? akn0[0] : akn15[0];
            if (a) begin lat = n; rd = (sel == 0) ? dout0 : dout15; end
        end
        stb0 = 1'b0; stb15 = 1'b0;
        check($sformatf("w%0d_read_lat", wc), 64'(lat), 64'(wc + 1));
        check($sformatf("w%0d_read_data", wc), 64'(rd), (sel == 0) ? 64'hA0 : 64'hB0);
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        int lat;
        logic [31:0] rd;
        logic [0:0] g;
        logic ok, errd;

        vecs[0] = '{0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        2};
        vecs[1] = '{0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 2};
        vecs[2] = '{1, 1'b1, 32'h44,  32'h12345678, 32'h0,        2};
        vecs[3] = '{1, 1'b0, 32'h44,  32'h0,        32'h12345678, 2};
        vecs[4] = '{0, 1'b0, 32'h46,  32'h0,        32'h12345678, 2};
        vecs[5] = '{1, 1'b1, 32'hFFC, 32'hA5A50001, 32'h0,        2};
        vecs[6] = '{0, 1'b0, 32'hFFC, 32'h0,        32'hA5A50001, 2};
        vecs[7] = '{1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 2};

        rst_n = 1'b0;
        stb = '0; we = '0; adr = '0; dat_i = '0;
        stb0 = '0; we0 = '0; adr0 = '0; din0 = '0;
        stb15 = '0; we15 = '0; adr15 = '0; din15 = '0;
        @(negedge clk); @(negedge clk);
        check("reset_akn", 64'(akn), 64'd0);
        check("reset_dat_o", dat_o, 64'd0);
        check("reset_gnt", 64'(gnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven single transactions.
        for (int i = 0; i < 8; i++) begin
            txn(vecs[i].port, vecs[i].wr, vecs[i].a, vecs[i].wd, lat, rd, g, ok, errd);
            check($sformatf("vec%0d_ack_seen", i), 64'(ok), 64'd1);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d_gnt", i), 64'(g), 64'(vecs[i].port));
            if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rd));
        end
        check("dat_o_p0_held", 64'(dat_o[31:0]), 64'hA5A50001);

        // Reset during WAIT of a write to 0x30 abandons it.
        txn(1, 1'b1, 32'h30, 32'h11112222, lat, rd, g, ok, errd);
        check("pre_abort_write_ack", 64'(ok), 64'd1);
        stb[1] = 1'b1; we[1] = 1'b1; adr[63:32] = 32'h30; dat_i[63:32] = 32'h99999999;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_reset_akn", 64'(akn), 64'd0);
        check("abort_reset_dat_o", dat_o, 64'd0);
        check("abort_reset_gnt", 64'(gnt), 64'd0);
        stb = '0;
        @(posedge clk); @(negedge clk);
        check("abort_no_akn", 64'(akn), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        txn(0, 1'b0, 32'h30, 32'h0, lat, rd, g, ok, errd);
        check("abort_readback", 64'(rd), 64'h11112222);

        // Fresh reset, then simultaneous write (p0) / read (p1) of 0x20.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        we = 2'b01; adr = {32'h20, 32'h20}; dat_i = {32'h0, 32'h5A5A5A5A};
        stb = 2'b11;
        watch_acks(2, 1'b1);
        check("simul_ack_count", 64'(na), 64'd2);
        check("simul_first_port", 64'(ack_v[0]), 64'b01);
        check("simul_first_gnt", 64'(ack_g[0]), 64'd0);
        check("simul_first_cycle", 64'(ack_n[0]), 64'd2);
        check("simul_second_port", 64'(ack_v[1]), 64'b10);
        check("simul_second_gnt", 64'(ack_g[1]), 64'd1);
        check("simul_second_cycle", 64'(ack_n[1]), 64'd5);
        check("simul_read_after_write", 64'(ack_d[1][63:32]), 64'h5A5A5A5A);
        @(posedge clk); @(negedge clk);

        // Both ports held high: grants rotate with one access per 3 cycles.
        we = 2'b00; adr = {32'h44, 32'h10};
        stb = 2'b11;
        watch_acks(4, 1'b0);
        check("burst_ack_count", 64'(na), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("burst%0d_gnt", i), 64'(ack_g[i]), 64'(i % 2));
            check($sformatf("burst%0d_cycle", i), 64'(ack_n[i]), 64'(2 + 3 * i));
            check($sformatf("burst%0d_rdata", i), 64'(ack_d[i][(i % 2) * 32 +: 32]),
                  (i % 2) ? 64'h12345678 : 64'hDEADBEEF);
        end
        @(posedge clk); @(negedge clk);

        // Address above DEPTH words: alias without the error option, ERR with it.
        txn(0, 1'b1, 32'h0, 32'h0BADF00D, lat, rd, g, ok, errd);
        txn(0, 1'b1, 32'h1000, 32'h600DCAFE, lat, rd, g, ok, errd);
`ifdef WB_MEM_ERR_EN
        check("oob_err_seen", 64'(errd), 64'd1);
        check("oob_no_akn", 64'(ok), 64'd0);
        check("oob_err_latency", 64'(lat), 64'd2);
        txn(0, 1'b0, 32'h0, 32'h0, lat, rd, g, ok, errd);
        check("oob_no_write", 64'(rd), 64'h0BADF00D);
`else
        check("alias_ack_seen", 64'(ok), 64'd1);
        txn(0, 1'b0, 32'h0, 32'h0, lat, rd, g, ok, errd);
        check("alias_readback", 64'(rd), 64'h600DCAFE);
`endif

        // Wait-state extremes.
        small_burst(0, 0);
        small_burst(1, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_wb_mem_arb
`default_nettype wire
